// File: rtl/ysyx_22050243_exu_op_seq_pkg.sv
// rtl/ysyx_22050243_exu_op_seq_pkg.sv - package ysyx_22050243_exu_defs: ALU codes, alu_op/funct3 encodings, FSM states
package ysyx_22050243_exu_defs;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_ILL  = 4'b1111;

    localparam logic [2:0] AOP_ADD       = 3'b000;
    localparam logic [2:0] AOP_OP_IMM    = 3'b011;
    localparam logic [2:0] AOP_OP        = 3'b100;
    localparam logic [2:0] AOP_OP_32     = 3'b101;
    localparam logic [2:0] AOP_OP_IMM_32 = 3'b110;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } op_state_e;

endpackage

// File: rtl/ysyx_22050243_exu_op_seq_if.sv
// rtl/ysyx_22050243_exu_op_seq_if.sv - ID/EX op input and EX/MEM result output handshakes
interface ysyx_22050243_exu_op_seq_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      alu_op;
    logic [3:0]      funct;
    logic            is_m;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] md_result;

    modport master (
        output in_valid, alu_op, funct, is_m, src1, src2, out_ready,
        input  in_ready, out_valid, alu_ctrl, md_result
    );

    modport slave (
        input  in_valid, alu_op, funct, is_m, src1, src2, out_ready,
        output in_ready, out_valid, alu_ctrl, md_result
    );
endinterface

// File: rtl/ysyx_22050243_alu_code_dec.sv
// rtl/ysyx_22050243_alu_code_dec.sv - combinational {alu_op,funct} -> 4-bit ALU code
// OP_32/OP_IMM_32 decode only when YSYX_22050243_EXU_RV64W_EN is defined
module ysyx_22050243_alu_code_dec
    import ysyx_22050243_exu_defs::*;
(
    input  logic [2:0] alu_op,
    input  logic [3:0] funct,
    output logic [3:0] alu_ctrl
);
`ifdef YSYX_22050243_EXU_RV64W_EN
    localparam bit W_EN = 1'b1;
`else
    localparam bit W_EN = 1'b0;
`endif

    logic [3:0] base_code;
    logic [3:0] imm_code;
    logic [3:0] reg_code;

    always_comb begin
        base_code = ALU_ADD;
        case (funct[2:0])
            3'b000: base_code = ALU_ADD;
            3'b001: base_code = ALU_SLL;
            3'b010: base_code = ALU_SLT;
            3'b011: base_code = ALU_SLTU;
            3'b100: base_code = ALU_XOR;
            3'b101: base_code = ALU_SRL;
            3'b110: base_code = ALU_OR;
            3'b111: base_code = ALU_AND;
        endcase

        // immediates carry arbitrary funct7 bits except on the shift-right form
        imm_code = (funct[3] && funct[2:0] == 3'b101) ? ALU_SRA : base_code;

        reg_code = base_code;
        if (funct[3]) begin
            case (funct[2:0])
                3'b000:  reg_code = ALU_SUB;
                3'b101:  reg_code = ALU_SRA;
                default: reg_code = ALU_ILL;
            endcase
        end

        alu_ctrl = ALU_ILL;
        case (alu_op)
            AOP_ADD:       alu_ctrl = ALU_ADD;
            AOP_OP_IMM:    alu_ctrl = imm_code;
            AOP_OP:        alu_ctrl = reg_code;
            AOP_OP_32:     alu_ctrl = W_EN ? reg_code : ALU_ILL;
            AOP_OP_IMM_32: alu_ctrl = W_EN ? imm_code : ALU_ILL;
            default:       alu_ctrl = ALU_ILL;
        endcase
    end
endmodule

// File: rtl/ysyx_22050243_exu_op_seq.sv
// rtl/ysyx_22050243_exu_op_seq.sv - EX op sequencer: ALU code decode plus iterative M-extension mul/div
// RV64 W-form M ops enabled by YSYX_22050243_EXU_RV64W_EN
module ysyx_22050243_exu_op_seq
    import ysyx_22050243_exu_defs::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    ysyx_22050243_exu_op_seq_if.slave        bus,
    output logic                             busy
);
`ifdef YSYX_22050243_EXU_RV64W_EN
    localparam bit W_EN = 1'b1;
`else
    localparam bit W_EN = 1'b0;
`endif

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    op_state_e         state, state_d;
    logic [3:0]        dec_ctrl;
    logic [2:0]        f3;
    logic              accept, m_op, w_op;
    logic              s1_signed, s2_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_val;
    logic              div_zero, div_ovf, div_special;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] init_acc, st_acc, step_acc, acc;
    logic [XLEN-1:0]   st_opnd, opnd;
    logic              st_div, ge;
    logic [XLEN:0]     sum, tmp, diff;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_f3;
    logic              op_w, neg_q, neg_r;
    logic [2*XLEN-1:0] prod_mag, prod_s;
    logic [XLEN-1:0]   quo, rem, raw_res, calc_res;
    logic [3:0]        alu_ctrl_q;
    logic [XLEN-1:0]   md_q;

    ysyx_22050243_alu_code_dec u_dec (
        .alu_op   (bus.alu_op),
        .funct    (bus.funct),
        .alu_ctrl (dec_ctrl)
    );

    assign f3     = bus.funct[2:0];
    assign w_op   = W_EN && (bus.alu_op == AOP_OP_32);
    assign m_op   = bus.is_m && ((bus.alu_op == AOP_OP) || w_op);
    assign accept = bus.in_valid && (state == ST_IDLE) && !flush;

    always_comb begin
        s1_signed = 1'b0;
        s2_signed = 1'b0;
        case (f3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                s1_signed = 1'b1;
                s2_signed = 1'b1;
            end
            F3_MULHSU:                 s1_signed = 1'b1;
            F3_MULHU, F3_DIVU, F3_REMU: s1_signed = 1'b0;
        endcase

        a_ext = bus.src1;
        b_ext = bus.src2;
        if (w_op) begin
            a_ext = s1_signed ? XLEN'($signed(bus.src1[31:0])) : XLEN'(bus.src1[31:0]);
            b_ext = s2_signed ? XLEN'($signed(bus.src2[31:0])) : XLEN'(bus.src2[31:0]);
        end
        a_neg = s1_signed && a_ext[XLEN-1];
        b_neg = s2_signed && b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        min_val     = w_op ? XLEN'($signed(32'h8000_0000)) : XMIN;
        div_zero    = (b_ext == '0);
        div_ovf     = s1_signed && (a_ext == min_val) && (b_ext == '1);
        div_special = f3[2] && (div_zero || div_ovf);
        if (div_zero)
            special_res = f3[1] ? a_ext : '1;
        else
            special_res = f3[1] ? '0 : min_val;
        if (w_op)
            special_res = XLEN'($signed(special_res[31:0]));

        // W divides walk only the low 32 dividend bits, so park them at the top of lo
        init_acc = {{XLEN{1'b0}}, (w_op && f3[2]) ? (a_mag << 32) : a_mag};
    end

    // One radix-2 step; in IDLE it runs on the fresh operands so accept counts as iteration 1
    always_comb begin
        st_acc   = (state == ST_IDLE) ? init_acc : acc;
        st_opnd  = (state == ST_IDLE) ? b_mag : opnd;
        st_div   = (state == ST_IDLE) ? f3[2] : op_f3[2];
        sum      = {1'b0, st_acc[2*XLEN-1:XLEN]} + (st_acc[0] ? {1'b0, st_opnd} : '0);
        tmp      = st_acc[2*XLEN-1:XLEN-1];
        diff     = tmp - {1'b0, st_opnd};
        ge       = !diff[XLEN];
        if (st_div)
            step_acc = {ge ? diff[XLEN-1:0] : tmp[XLEN-1:0], st_acc[XLEN-2:0], ge};
        else
            step_acc = {sum, st_acc[XLEN-1:1]};
    end

    always_comb begin
        prod_mag = op_w ? (2*XLEN)'(acc[XLEN+31:XLEN-32]) : acc;
        prod_s   = neg_q ? -prod_mag : prod_mag;
        quo      = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem      = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        raw_res  = '0;
        case (op_f3)
            F3_MUL:                       raw_res = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: raw_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              raw_res = quo;
            F3_REM, F3_REMU:              raw_res = rem;
        endcase
        calc_res = op_w ? XLEN'($signed(raw_res[31:0])) : raw_res;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (accept) state_d = (m_op && !div_special) ? ST_CALC : ST_DONE;
            ST_CALC: if (cnt == '0) state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            opnd       <= '0;
            cnt        <= '0;
            op_f3      <= '0;
            op_w       <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            alu_ctrl_q <= ALU_ADD;
            md_q       <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                op_f3 <= f3;
                op_w  <= w_op;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                if (!m_op) begin
                    alu_ctrl_q <= dec_ctrl;
                    md_q       <= '0;
                end else begin
                    alu_ctrl_q <= ALU_ILL;
                    if (div_special) begin
                        md_q <= special_res;
                    end else begin
                        acc  <= step_acc;
                        opnd <= b_mag;
                        cnt  <= w_op ? CNT_W'(31) : CNT_W'(XLEN - 1);
                    end
                end
            end
        end else if (state == ST_CALC) begin
            if (cnt != '0) begin
                acc <= step_acc;
                cnt <= cnt - 1'b1;
            end else begin
                md_q <= calc_res;
            end
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.md_result = md_q;
    assign busy          = (state != ST_IDLE);
endmodule
